fp_align: RTL and testbench

- Operand-alignment stage that sits directly upstream of fp_add_sub and feeds it.
- Accepts two single-precision operands and an op code.
- Orders the operands so that x1 has the larger magnitude, then right-shifts the smaller significand by the exponent difference into PRECISION guard bits.
- Two-stage valid/ready pipeline with full backpressure, so the FPU can stall the adder without losing operands.

---
 rtl/fp_align.sv | 175 +++++++++++++++++
 tb/tb_fp_align.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_align.sv
// Operand-alignment stage ahead of fp_add_sub: orders two singles by magnitude and shifts the smaller one.
// Optional macro FP_ALIGN_STICKY_EN folds every shifted-out bit into x2_mant[0].
package fp_align_pkg;
  typedef logic [1:0] fp_op_t;
endpackage

module fp_align
  import fp_align_pkg::*;
#(
  parameter int PRECISION = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   a_sign,
  input  logic                   b_sign,
  input  logic [7:0]             a_exp,
  input  logic [7:0]             b_exp,
  input  logic [22:0]            a_frac,
  input  logic [22:0]            b_frac,
  input  fp_op_t                 op_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   x1_sign,
  output logic                   x2_sign,
  output logic [7:0]             x1_exp,
  output logic [23+PRECISION-1:0] x1_mant,
  output logic [23+PRECISION-1:0] x2_mant,
  output logic                   switched,
  output logic                   swapped,
  output logic                   special,
  output fp_op_t                 op_out
);

  localparam int         MW  = 23 + PRECISION;
  localparam int         SW  = 24 + PRECISION;
  localparam logic [7:0] SW8 = 8'(SW);

  // Ready chain: each stage may load when it is empty or the stage after it moves.
  logic w_s2_adv;
  logic w_s1_adv;

  logic          r1_valid;
  logic          r1_x1_sign;
  logic          r1_x2_sign;
  logic [7:0]    r1_x1_exp;
  logic [22:0]   r1_x1_frac;
  logic [23:0]   r1_x2_sig;
  logic [7:0]    r1_d;
  logic          r1_switched;
  logic          r1_swapped;
  logic          r1_special;
  fp_op_t        r1_op;

  logic          r2_valid;
  logic          r2_x1_sign;
  logic          r2_x2_sign;
  logic [7:0]    r2_x1_exp;
  logic [MW-1:0] r2_x1_mant;
  logic [MW-1:0] r2_x2_mant;
  logic          r2_switched;
  logic          r2_swapped;
  logic          r2_special;
  fp_op_t        r2_op;

  assign w_s2_adv = !r2_valid || out_ready;
  assign w_s1_adv = !r1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // Stage 1: compare and swap, exponent-0 operands flushed to zero.
  logic        w_swap;
  logic [7:0]  w_x1_exp;
  logic [7:0]  w_x2_exp;
  logic [22:0] w_x1_frac_raw;
  logic [22:0] w_x2_frac_raw;
  logic [22:0] w_x1_frac;
  logic [23:0] w_x2_sig;
  logic        w_special;

  assign w_swap        = (b_exp > a_exp) || ((b_exp == a_exp) && (b_frac > a_frac));
  assign w_x1_exp      = w_swap ? b_exp  : a_exp;
  assign w_x2_exp      = w_swap ? a_exp  : b_exp;
  assign w_x1_frac_raw = w_swap ? b_frac : a_frac;
  assign w_x2_frac_raw = w_swap ? a_frac : b_frac;
  assign w_x1_frac     = (w_x1_exp == 8'd0) ? 23'd0 : w_x1_frac_raw;
  assign w_x2_sig      = (w_x2_exp == 8'd0) ? 24'd0 : {1'b1, w_x2_frac_raw};
  assign w_special     = (a_exp == 8'hFF) || (b_exp == 8'hFF);

  // Stage 2: right shift of the smaller significand into the guard bits.
  logic [SW-1:0] w_sig_ext;
  logic [MW-1:0] w_shifted;
  logic [MW-1:0] w_x2_mant;

  assign w_sig_ext = {r1_x2_sig, {PRECISION{1'b0}}};
  assign w_shifted = (r1_d >= SW8) ? '0 : MW'(w_sig_ext >> r1_d);

`ifdef FP_ALIGN_STICKY_EN
  logic [SW-1:0] w_lost;
  for (genvar gi = 0; gi < SW; gi++) begin : g_sticky
    assign w_lost[gi] = w_sig_ext[gi] && (r1_d > 8'(gi));
  end
  assign w_x2_mant = w_shifted | {{(MW-1){1'b0}}, |w_lost};
`else
  assign w_x2_mant = w_shifted;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid    <= 1'b0;
      r1_x1_sign  <= 1'b0;
      r1_x2_sign  <= 1'b0;
      r1_x1_exp   <= '0;
      r1_x1_frac  <= '0;
      r1_x2_sig   <= '0;
      r1_d        <= '0;
      r1_switched <= 1'b0;
      r1_swapped  <= 1'b0;
      r1_special  <= 1'b0;
      r1_op       <= '0;
      r2_valid    <= 1'b0;
      r2_x1_sign  <= 1'b0;
      r2_x2_sign  <= 1'b0;
      r2_x1_exp   <= '0;
      r2_x1_mant  <= '0;
      r2_x2_mant  <= '0;
      r2_switched <= 1'b0;
      r2_swapped  <= 1'b0;
      r2_special  <= 1'b0;
      r2_op       <= '0;
    end else begin
      if (w_s1_adv) begin
        r1_valid <= in_valid;
        if (in_valid) begin
          r1_x1_sign  <= w_swap ? b_sign : a_sign;
          r1_x2_sign  <= w_swap ? a_sign : b_sign;
          r1_x1_exp   <= w_x1_exp;
          r1_x1_frac  <= w_x1_frac;
          r1_x2_sig   <= w_x2_sig;
          r1_d        <= w_x1_exp - w_x2_exp;
          r1_switched <= (w_x1_exp != w_x2_exp);
          r1_swapped  <= w_swap;
          r1_special  <= w_special;
          r1_op       <= op_in;
        end
      end
      if (w_s2_adv) begin
        r2_valid <= r1_valid;
        if (r1_valid) begin
          r2_x1_sign  <= r1_x1_sign;
          r2_x2_sign  <= r1_x2_sign;
          r2_x1_exp   <= r1_x1_exp;
          r2_x1_mant  <= {r1_x1_frac, {PRECISION{1'b0}}};
          r2_x2_mant  <= w_x2_mant;
          r2_switched <= r1_switched;
          r2_swapped  <= r1_swapped;
          r2_special  <= r1_special;
          r2_op       <= r1_op;
        end
      end
    end
  end

  assign out_valid = r2_valid;
  assign x1_sign   = r2_x1_sign;
  assign x2_sign   = r2_x2_sign;
  assign x1_exp    = r2_x1_exp;
  assign x1_mant   = r2_x1_mant;
  assign x2_mant   = r2_x2_mant;
  assign switched  = r2_switched;
  assign swapped   = r2_swapped;
  assign special   = r2_special;
  assign op_out    = r2_op;

endmodule

// File: tb/tb_fp_align.sv
// Self-checking bench for fp_align: directed vector table, latency/backpressure/reset sequences,
// and a randomized stream scored against an arithmetic reference model.
module tb_fp_align;
  import fp_align_pkg::*;

  localparam int P  = 3;
  localparam int MW = 23 + P;
`ifdef FP_ALIGN_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  typedef struct packed {
    logic          x1_sign;
    logic          x2_sign;
    logic [7:0]    x1_exp;
    logic [MW-1:0] x1_mant;
    logic [MW-1:0] x2_mant;
    logic          switched;
    logic          swapped;
    logic          special;
    fp_op_t        op;
  } out_t;

  typedef struct {
    logic        as;
    logic [7:0]  ae;
    logic [22:0] af;
    logic        bs;
    logic [7:0]  be;
    logic [22:0] bf;
    fp_op_t      op;
    out_t        exp;
  } vec_t;

  logic clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic a_sign, b_sign, x1_sign, x2_sign, switched, swapped, special;
  logic [7:0] a_exp, b_exp, x1_exp;
  logic [22:0] a_frac, b_frac;
  logic [MW-1:0] x1_mant, x2_mant;
  fp_op_t op_in, op_out;

  fp_align #(.PRECISION(P)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
    .a_frac(a_frac), .b_frac(b_frac), .op_in(op_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x1_sign(x1_sign), .x2_sign(x2_sign), .x1_exp(x1_exp),
    .x1_mant(x1_mant), .x2_mant(x2_mant), .switched(switched),
    .swapped(swapped), .special(special), .op_out(op_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_beats = 0;
  out_t sb[$];
  out_t exp_next;
  logic last_in_ready;
  logic prev_stall = 1'b0;
  out_t stall_snap;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic out_t mk_out(input logic s1, input logic s2, input logic [7:0] e1,
                                  input logic [MW-1:0] m1, input logic [MW-1:0] m2,
                                  input logic sw, input logic sp, input logic spc, input fp_op_t op);
    out_t r;
    r.x1_sign = s1; r.x2_sign = s2; r.x1_exp = e1; r.x1_mant = m1; r.x2_mant = m2;
    r.switched = sw; r.swapped = sp; r.special = spc; r.op = op;
    return r;
  endfunction

  // Reference: magnitudes compared as integers, alignment as division by 2^d.
  function automatic out_t model(input logic as, input logic [7:0] ae, input logic [22:0] af,
                                 input logic bs, input logic [7:0] be, input logic [22:0] bf,
                                 input fp_op_t op);
    out_t r;
    longint ma, mb, sig, q, pw;
    logic swp, s1, s2;
    logic [7:0] e1, e2;
    logic [22:0] f1, f2;
    int d;
    ma  = longint'(ae) * 64'd8388608 + longint'(af);
    mb  = longint'(be) * 64'd8388608 + longint'(bf);
    swp = (mb > ma);
    s1 = swp ? bs : as;  s2 = swp ? as : bs;
    e1 = swp ? be : ae;  e2 = swp ? ae : be;
    f1 = swp ? bf : af;  f2 = swp ? af : bf;
    d   = int'(e1) - int'(e2);
    sig = (e2 == 8'd0) ? 64'd0 : (64'd8388608 + longint'(f2)) * (64'd1 << P);
    if (d >= 24 + P) begin
      q = 0;
      pw = 0;
    end else begin
      pw = 64'd1 << d;
      q  = sig / pw;
    end
    r.x2_mant = MW'(q % (64'd1 << MW));
    if (STK && sig != 0 && (d >= 24 + P || (sig % pw) != 0)) r.x2_mant[0] = 1'b1;
    r.x1_mant  = (e1 == 8'd0) ? '0 : MW'(longint'(f1) * (64'd1 << P));
    r.x1_sign  = s1;
    r.x2_sign  = s2;
    r.x1_exp   = e1;
    r.switched = (d != 0);
    r.swapped  = swp;
    r.special  = (ae == 8'hFF) || (be == 8'hFF);
    r.op       = op;
    return r;
  endfunction

  function automatic out_t dut_out();
    return mk_out(x1_sign, x2_sign, x1_exp, x1_mant, x2_mant, switched, swapped, special, op_out);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end else begin
      $display("[TB] %s ok %h", name, act);
    end
  endtask

  task automatic set_in(input logic as, input logic [7:0] ae, input logic [22:0] af,
                        input logic bs, input logic [7:0] be, input logic [22:0] bf, input fp_op_t op);
    a_sign = as; a_exp = ae; a_frac = af;
    b_sign = bs; b_exp = be; b_frac = bf;
    op_in = op; in_valid = 1'b1;
  endtask

  task automatic rand_pair();
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    int mode;
    ea   = 8'($urandom_range(0, 255));
    mode = $urandom_range(0, 3);
    if (mode == 0) eb = ea;
    else if (mode == 1) eb = 8'($urandom_range(0, 255));
    else eb = 8'(int'(ea) + $urandom_range(0, 30) - 15);
    fa = 23'($urandom);
    fb = ($urandom_range(0, 7) == 0) ? fa : 23'($urandom);
    set_in(1'($urandom), ea, fa, 1'($urandom), eb, fb, fp_op_t'($urandom));
    exp_next = model(a_sign, a_exp, a_frac, b_sign, b_exp, b_frac, op_in);
  endtask

  // One clock: score the output beat and log the input beat, then move to #1 after posedge.
  task automatic step(output bit acc);
    out_t got, want;
    @(negedge clk);
    acc = 1'b0;
    last_in_ready = in_ready;
    got = dut_out();
    if (out_valid && !out_ready) begin
      if (prev_stall) check("hold", 128'(got), 128'(stall_snap));
      prev_stall = 1'b1;
      stall_snap = got;
    end else begin
      prev_stall = 1'b0;
    end
    if (out_valid && out_ready) begin
      n_beats++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h required none", got);
      end else begin
        want = sb.pop_front();
        check("beat", 128'(got), 128'(want));
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(exp_next);
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[6];

  initial begin
    bit acc;
    int sent, base, budget;
    bit pending, saw_stall;

    vecs[0] = '{1'b1, 8'd127, 23'h0, 1'b0, 8'd127, 23'h400000, 2'd1,
                mk_out(1'b0, 1'b1, 8'd127, MW'(26'h2000000), '0, 1'b0, 1'b1, 1'b0, 2'd1)};
    vecs[1] = '{1'b0, 8'd129, 23'h0, 1'b0, 8'd127, 23'h0, 2'd2,
                mk_out(1'b0, 1'b0, 8'd129, '0, MW'(26'h1000000), 1'b1, 1'b0, 1'b0, 2'd2)};
    vecs[2] = '{1'b0, 8'd160, 23'h0, 1'b1, 8'd100, 23'h1, 2'd0,
                mk_out(1'b0, 1'b1, 8'd160, '0, MW'(STK), 1'b1, 1'b0, 1'b0, 2'd0)};
    vecs[3] = '{1'b0, 8'd255, 23'h0, 1'b0, 8'd127, 23'h0, 2'd3,
                mk_out(1'b0, 1'b0, 8'd255, '0, MW'(STK), 1'b1, 1'b0, 1'b1, 2'd3)};
    vecs[4] = '{1'b1, 8'd130, 23'h123456, 1'b0, 8'd130, 23'h123456, 2'd1,
                mk_out(1'b1, 1'b0, 8'd130, MW'(26'h91A2B0), MW'(26'h91A2B0), 1'b0, 1'b0, 1'b0, 2'd1)};
    vecs[5] = '{1'b0, 8'd0, 23'h7FFFFF, 1'b1, 8'd1, 23'h0, 2'd2,
                mk_out(1'b1, 1'b0, 8'd1, '0, '0, 1'b1, 1'b1, 1'b0, 2'd2)};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_sign = 0; b_sign = 0; a_exp = 0; b_exp = 0; a_frac = 0; b_frac = 0; op_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_data", 128'(dut_out()), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));

    // Latency on an empty pipe.
    out_ready = 1'b1;
    set_in(vecs[1].as, vecs[1].ae, vecs[1].af, vecs[1].bs, vecs[1].be, vecs[1].bf, vecs[1].op);
    exp_next = vecs[1].exp;
    step(acc);
    in_valid = 1'b0;
    check("lat_accept", 128'(acc), 128'(1));
    check("lat_cycle1", 128'(out_valid), 128'(0));
    step(acc);
    check("lat_cycle2", 128'(out_valid), 128'(1));
    step(acc);

    // Directed table, back to back.
    for (int i = 0; i < 6; i++) begin
      set_in(vecs[i].as, vecs[i].ae, vecs[i].af, vecs[i].bs, vecs[i].be, vecs[i].bf, vecs[i].op);
      exp_next = vecs[i].exp;
      budget = 0;
      do begin
        step(acc);
        budget++;
      end while (!acc && budget < 20);
      if (!acc) check("vec_accept", 128'(acc), 128'(1));
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && sb.size() != 0; c++) step(acc);
    check("vec_drain", 128'(sb.size()), 128'(0));

    // Backpressure: six pairs with out_ready low for cycles 3..6.
    sent = 0; base = n_beats; saw_stall = 0; pending = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      if (!pending && sent < 6) begin
        rand_pair();
        pending = 1;
      end
      step(acc);
      if (pending && !last_in_ready) saw_stall = 1;
      if (acc) begin
        pending = 0;
        in_valid = 1'b0;
        sent++;
      end
      if (sent == 6 && sb.size() == 0) break;
    end
    check("bp_stall_seen", 128'(saw_stall), 128'(1));
    check("bp_beat_count", 128'(n_beats - base), 128'(6));

    // Randomized stream with random backpressure.
    sent = 0; pending = 0;
    for (int cyc = 0; cyc < 5000 && sent < 300; cyc++) begin
      if (!pending && $urandom_range(0, 9) < 7) begin
        rand_pair();
        pending = 1;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step(acc);
      if (acc) begin
        pending = 0;
        in_valid = 1'b0;
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("rand_sent", 128'(sent), 128'(300));
    for (int c = 0; c < 20 && sb.size() != 0; c++) step(acc);
    check("rand_drain", 128'(sb.size()), 128'(0));

    // Reset with both stages full: nothing may emerge afterwards.
    out_ready = 1'b0; sent = 0; pending = 0;
    for (int c = 0; c < 10 && sent < 2; c++) begin
      if (!pending) begin
        rand_pair();
        pending = 1;
      end
      step(acc);
      if (acc) begin
        pending = 0;
        in_valid = 1'b0;
        sent++;
      end
    end
    in_valid = 1'b0;
    check("rst_full_out_valid", 128'(out_valid), 128'(1));
    check("rst_full_in_ready", 128'(in_ready), 128'(0));
    rst = 1'b1;
    step(acc);
    rst = 1'b0;
    sb.delete();
    check("rst_mid_out_valid", 128'(out_valid), 128'(0));
    check("rst_mid_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    base = n_beats;
    repeat (6) step(acc);
    check("rst_no_stale", 128'(n_beats - base), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
